// File: rtl/cnt_arb_pkg.sv
// cnt_arb_pkg: state type and default sizes for the counter arbiter
package cnt_arb_pkg;
  typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} cnt_arb_state_e;
  localparam int N_DEF = 4;
  localparam int W_DEF = 16;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or above ptr, wrapping
module rr_pick import cnt_arb_pkg::*; #(
  parameter int N = N_DEF
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] idx,
  output logic                 valid
);
  localparam int IW = $clog2(N);
  assign valid = |req;
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) if (req[IW'((int'(ptr) + i) % N)]) idx = IW'((int'(ptr) + i) % N);
  end
endmodule

// File: rtl/cnt_arb.sv
// cnt_arb: round-robin arbiter granting one requester at a time the shared counter up to its threshold
module cnt_arb import cnt_arb_pkg::*; #(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N-1:0]         req_i,
  input  logic [N*W-1:0]       thr_i,
  output logic [N-1:0]         gnt_o,
  output logic [N-1:0]         done_o,
  output logic                 busy_o,
  output logic [$clog2(N)-1:0] owner_o,
  output logic                 cnt_clr_o,
  output logic                 cnt_en_o,
  output logic [W-1:0]         cnt_thr_o,
  input  logic                 cnt_tc_i
);
  localparam int IW = $clog2(N);
  cnt_arb_state_e state;
  logic [IW-1:0] owner, ptr, idx, nxt;
  logic valid, wd;
  logic [W-1:0] thr_a [N];
  for (genvar k = 0; k < N; k++) begin : g_thr
    assign thr_a[k] = thr_i[k*W +: W];
  end
  rr_pick #(.N(N)) u_pick (.req(req_i), .ptr(ptr), .idx(idx), .valid(valid));
  assign nxt = owner == IW'(N - 1) ? '0 : owner + 1'b1;
  assign wd = (state == CLR || state == RUN) && !req_i[owner];
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      cnt_thr_o <= '0;
    end else begin
      case (state)
        IDLE: if (valid) begin
          state     <= CLR;
          owner     <= idx;
          cnt_thr_o <= thr_a[idx];
        end
        CLR: begin
          state <= wd ? IDLE : RUN;
          if (wd) ptr <= nxt;
        end
        RUN: begin
          state <= wd ? IDLE : cnt_tc_i ? DONE : RUN;
          if (wd) ptr <= nxt;
        end
        DONE: begin
          state <= IDLE;
          ptr   <= nxt;
        end
      endcase
    end
  end
  always_comb begin
    busy_o    = !rst_i && state != IDLE;
    gnt_o     = busy_o ? N'(1) << owner : '0;
    done_o    = busy_o && state == DONE ? N'(1) << owner : '0;
    owner_o   = busy_o ? owner : '0;
    cnt_clr_o = rst_i || state == CLR || wd;
    cnt_en_o  = !rst_i && state == RUN && !cnt_tc_i;
  end
endmodule

// File: tb/tb_cnt_arb.sv
// tb_cnt_arb: directed bench with a tenure-level reference model and the shared counter
module tb_cnt_arb;
  localparam int N = 4;
  localparam int W = 16;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic [N-1:0] req_i = '0;
  logic [N*W-1:0] thr_i = '0;
  logic [N-1:0] gnt_o, done_o;
  logic busy_o, cnt_clr_o, cnt_en_o, cnt_tc_i;
  logic [1:0] owner_o;
  logic [W-1:0] cnt_thr_o;
  logic [W-1:0] cnt = '0;
  int tests = 0;
  int fails = 0;
  bit chk_on = 0;
  bit auto_drop = 0;
  bit m_active = 0;
  int m_owner = 0;
  int m_age = 0;
  int m_thr = 0;
  int m_ptr = 0;
  bit e_busy;
  int glog[$];
  int dlog[$];
  int en_cnt, clr_cnt, busy_cnt;
  logic [N-1:0] prev_gnt = '0;
  int exp5[5] = '{0, 1, 2, 3, 0};

  always #5 clk_i = ~clk_i;

  cnt_arb #(.N(N), .W(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .thr_i(thr_i),
    .gnt_o(gnt_o), .done_o(done_o), .busy_o(busy_o), .owner_o(owner_o),
    .cnt_clr_o(cnt_clr_o), .cnt_en_o(cnt_en_o), .cnt_thr_o(cnt_thr_o), .cnt_tc_i(cnt_tc_i)
  );

  assign cnt_tc_i = cnt == cnt_thr_o;
  always @(posedge clk_i) begin
    if (cnt_clr_o) cnt <= '0;
    else if (cnt_en_o) cnt <= cnt + 1'b1;
  end

  function automatic int rr(logic [N-1:0] r, int p);
    for (int i = 0; i < N; i++) if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  function automatic int thr_of(logic [N*W-1:0] t, int k);
    return int'(W'(t >> (k * W)));
  endfunction

  function automatic bit m_wd();
    return m_active && m_age <= m_thr + 1 && !req_i[m_owner];
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Tenure model: a grant lasts one clear cycle, thr+1 run cycles and one done cycle.
  always @(posedge clk_i) begin
    if (rst_i) begin
      m_active <= 0;
      m_ptr    <= 0;
      m_thr    <= 0;
    end else if (!m_active) begin
      if (req_i != '0) begin
        m_active <= 1;
        m_owner  <= rr(req_i, m_ptr);
        m_age    <= 0;
        m_thr    <= thr_of(thr_i, rr(req_i, m_ptr));
      end
    end else if (m_wd() || m_age == m_thr + 2) begin
      m_active <= 0;
      m_ptr    <= (m_owner + 1) % N;
    end else m_age <= m_age + 1;
  end

  always @(negedge clk_i) begin
    if (chk_on) begin
      e_busy = !rst_i && m_active;
      check("gnt", gnt_o, e_busy ? 4'(1 << m_owner) : 4'd0);
      check("done", done_o, e_busy && m_age == m_thr + 2 ? 4'(1 << m_owner) : 4'd0);
      check("busy", busy_o, e_busy);
      check("owner", owner_o, e_busy ? m_owner : 0);
      check("clr", cnt_clr_o, rst_i || (m_active && m_age == 0) || m_wd());
      check("en", cnt_en_o, e_busy && m_age >= 1 && m_age <= m_thr);
      check("thr", cnt_thr_o, m_thr);
      if (!rst_i) begin
        if (cnt_en_o) en_cnt++;
        if (cnt_clr_o) clr_cnt++;
        if (busy_o) busy_cnt++;
        if (done_o != '0) dlog.push_back(int'(owner_o));
        if (gnt_o != '0 && gnt_o != prev_gnt) glog.push_back(int'(owner_o));
      end
      prev_gnt = gnt_o;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
    if (auto_drop) req_i = req_i & ~done_o;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    req_i = '0;
    tick();
    chk_on = 1;
    tick();
    check("rst_clr", cnt_clr_o, 1);
    check("rst_gnt", gnt_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_thr", cnt_thr_o, 0);
    rst_i = 1'b0;
    glog.delete();
    dlog.delete();
    en_cnt = 0;
    clr_cnt = 0;
    busy_cnt = 0;
  endtask

  initial begin
    do_reset();
    thr_i = {16'd0, 16'd0, 16'd5, 16'd0};
    auto_drop = 1;
    req_i = 4'b0010;
    tick();
    check("single_gnt_latency", gnt_o, 4'b0010);
    repeat (11) tick();
    check("single_en_cycles", en_cnt, 5);
    check("single_clr_cycles", clr_cnt, 1);
    check("single_busy_cycles", busy_cnt, 8);
    check("single_done_count", dlog.size(), 1);
    check("single_done_idx", dlog.size() > 0 ? dlog[0] : -1, 1);
    check("single_idle_after", busy_o, 0);

    do_reset();
    thr_i = {4{16'd2}};
    auto_drop = 0;
    req_i = 4'b1111;
    repeat (30) tick();
    req_i = '0;
    repeat (10) tick();
    check("fair_grant_count", glog.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("fair_grant_%0d", i), glog.size() > i ? glog[i] : -1, exp5[i]);
      check($sformatf("fair_done_%0d", i), dlog.size() > i ? dlog[i] : -1, exp5[i]);
    end

    do_reset();
    thr_i = {4{16'd0}};
    auto_drop = 1;
    req_i = 4'b0001;
    repeat (8) tick();
    check("zero_busy_cycles", busy_cnt, 3);
    check("zero_en_cycles", en_cnt, 0);
    check("zero_done_count", dlog.size(), 1);
    check("zero_done_idx", dlog.size() > 0 ? dlog[0] : -1, 0);

    do_reset();
    thr_i = {16'd0, 16'd10, 16'd0, 16'd0};
    req_i = 4'b0100;
    tick();
    repeat (4) tick();
    req_i = '0;
    #1;
    check("wd_clr", cnt_clr_o, 1);
    tick();
    check("wd_idle", busy_o, 0);
    repeat (2) tick();
    check("wd_no_done", dlog.size(), 0);
    req_i = 4'b1111;
    tick();
    check("wd_ptr_next", owner_o, 3);
    req_i = '0;
    repeat (3) tick();

    do_reset();
    thr_i = {4{16'd2}};
    req_i = 4'b0001;
    tick();
    repeat (3) tick();
    check("tcwd_tc", cnt_tc_i, 1);
    req_i = '0;
    #1;
    check("tcwd_done", done_o, 0);
    check("tcwd_clr", cnt_clr_o, 1);
    tick();
    check("tcwd_idle", busy_o, 0);
    check("tcwd_no_done", dlog.size(), 0);
    req_i = 4'b1111;
    tick();
    check("tcwd_ptr_next", owner_o, 1);
    req_i = '0;
    repeat (3) tick();

    do_reset();
    thr_i = {16'd0, 16'd0, 16'd5, 16'd0};
    req_i = 4'b0010;
    tick();
    repeat (3) tick();
    rst_i = 1'b1;
    #1;
    check("mrst_gnt", gnt_o, 0);
    check("mrst_en", cnt_en_o, 0);
    check("mrst_clr", cnt_clr_o, 1);
    tick();
    check("mrst_thr", cnt_thr_o, 0);
    check("mrst_owner", owner_o, 0);
    check("mrst_done", done_o, 0);
    rst_i = 1'b0;
    req_i = 4'b1000;
    tick();
    check("mrst_first_gnt", gnt_o, 4'b1000);
    check("mrst_no_done", dlog.size(), 0);
    req_i = '0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cnt_arb.md
CNT_ARB -- requirements
Module: cnt_arb

Interface
REQ-001 Parameter N, default 4: number of requesters, N >= 2.
REQ-002 Parameter W, default 16: counter and threshold width.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 req_i  input  N  per-requester request level; held high until done_o or withdrawn.
REQ-006 thr_i  input  N*W  per-requester threshold; slice k is bits [k*W +: W].
REQ-007 gnt_o  output  N  one-hot grant; all zero when idle.
REQ-008 done_o  output  N  one-cycle completion pulse to the owner.
REQ-009 busy_o  output  1  high in any state other than IDLE.
REQ-010 owner_o  output  clog2(N)  index of the current owner; 0 when idle.
REQ-011 cnt_clr_o  output  1  synchronous clear to the shared counter.
REQ-012 cnt_en_o  output  1  count enable to the shared counter.
REQ-013 cnt_thr_o  output  W  threshold driven to the shared counter.
REQ-014 cnt_tc_i  input  1  counter terminal-count flag, high when the count equals cnt_thr_o.

Function
REQ-015 The FSM SHALL have four states: IDLE, CLR, RUN and DONE.
REQ-016 IDLE with any req_i bit high SHALL select a winner by round-robin from pointer ptr and move to CLR next cycle.
REQ-017 Round-robin SHALL pick the first set bit at or above ptr, wrapping modulo N.
REQ-018 On the IDLE->CLR edge, owner SHALL register the winner and cnt_thr_o SHALL register thr_i[owner]; cnt_thr_o holds until the next grant.
REQ-019 gnt_o[owner] SHALL be high in CLR, RUN and DONE, and low in IDLE.
REQ-020 CLR SHALL assert cnt_clr_o for exactly one cycle, with cnt_en_o low, then go to RUN.
REQ-021 In RUN, cnt_en_o SHALL equal NOT cnt_tc_i, combinationally, so the counter stops on the threshold.
REQ-022 RUN with cnt_tc_i high SHALL move to DONE.
REQ-023 DONE SHALL assert done_o[owner] for one cycle, set ptr to (owner+1) mod N, and return to IDLE.
REQ-024 Withdrawal: if req_i[owner] is low in CLR or RUN, the block SHALL go to IDLE next cycle with no done_o.
REQ-025 On withdrawal, the block SHALL assert cnt_clr_o in that same cycle and set ptr to (owner+1) mod N.
REQ-026 Withdrawal and cnt_tc_i high in the same RUN cycle: withdrawal wins, with no done_o.
REQ-027 thr_i[owner]=0: cnt_tc_i is high on the first RUN cycle, so RUN lasts one cycle with cnt_en_o low.
REQ-028 Requests arriving while busy_o is high SHALL wait; arbitration happens only in IDLE.
REQ-029 Minimum occupancy per grant SHALL be 3 cycles (CLR, RUN, DONE).
REQ-030 Grant latency SHALL be 1 cycle from req_i sampled in IDLE to gnt_o.
REQ-031 Changes to thr_i after the grant edge SHALL have no effect on cnt_thr_o.

Reset
REQ-032 With rst_i high at a clock edge, the block SHALL set state IDLE, ptr 0, owner 0 and cnt_thr_o 0.
REQ-033 While rst_i is high, gnt_o, done_o, busy_o and cnt_en_o SHALL be 0 and cnt_clr_o SHALL be 1.
REQ-034 Reset mid-RUN SHALL abandon the grant silently, with no done_o.
REQ-035 After rst_i deasserts, the first arbitration SHALL be possible in the first cycle.

Structure
REQ-036 The package cnt_arb_pkg SHALL hold the state enum type cnt_arb_state_e and the default constants for N and W.
REQ-037 The round-robin picker SHALL be the sub-module rr_pick: combinational, inputs req and ptr, outputs idx and valid.
REQ-038 cnt_arb SHALL instantiate the existing shared counter only in the testbench, never internally.

Verification
REQ-039 Single request: N=4, W=16, req_i=0010, thr[1]=5 -> gnt_o=0010 next cycle, one clr cycle, cnt_en_o high 5 cycles, done_o=0010 pulse, busy_o low after.
REQ-040 Fairness: req_i=1111 held, all thr=2 -> grant order 0,1,2,3,0; each done_o exactly once per round.
REQ-041 Zero threshold: req_i=0001, thr[0]=0 -> CLR, then RUN with cnt_en_o low, then done_o=0001; 3 busy cycles total.
REQ-042 Withdrawal: req_i=0100, thr[2]=10, drop req_i[2] at RUN cycle 4 -> cnt_clr_o high, IDLE next, no done_o, ptr=3.
REQ-043 Simultaneous tc and withdrawal in the same RUN cycle -> no done_o, state IDLE, ptr advanced.
REQ-044 Reset mid-RUN: rst_i high at RUN cycle 3 -> all outputs zero next cycle except cnt_clr_o=1; after release, req_i=1000 -> grant 3 (ptr 0, first set bit at or above ptr).
